// File: rtl/pll_dyn_ctrl.sv
// pll_dyn_ctrl
//   Sequencing and dynamic-ratio controller for a GTP_PLL_E3 instance.
//   Runs a reset -> lock filter -> ready sequence with a lock timeout and a
//   bounded number of retries. It accepts runtime divider/duty reconfiguration
//   through a valid/ready handshake.
//
// Ports
//   clk            in   free-running reference clock (PLL input clock)
//   rst_n          in   asynchronous active-low reset
//   cfg_valid      in   reconfiguration request
//   cfg_ready      out  request can be accepted (LOCKED or FAIL)
//   cfg_idiv       in   requested input divider
//   cfg_fdiv       in   requested feedback divider
//   cfg_odiv       in   requested output dividers, channel 0 in the LSBs
//   cfg_duty       in   requested duty values (half-VCO-cycle units)
//   pll_lock_raw   in   PLL LOCK, asynchronous to clk
//   pll_rst        out  PLL RST
//   ratioi/ratiof  out  PLL RATIOI / RATIOF
//   ratio_o/duty_o out  PLL RATIO0..n / DUTY0..n
//   clk_ready      out  filtered lock indication
//   busy           out  sequence in progress (RESET or WAIT_LOCK)
//   cfg_err        out  one-cycle pulse when a request is rejected
//   fail           out  retries exhausted
//   lock_loss_cnt  out  saturating count of lock drops while LOCKED
//
// State      | meaning
// -----------+---------------------------------------------------------
// ST_RESET   | PLL held in reset for RST_CYCLES cycles
// ST_WAIT    | waiting for LOCK_FILTER consecutive lock samples, with timeout
// ST_LOCKED  | lock qualified, clk_ready high, requests accepted
// ST_FAIL    | retries exhausted, PLL held in reset until a good request

module pll_dyn_ctrl #(
  parameter int                           NUM_OUT      = 1,
  parameter int                           RATIO_W      = 10,
  parameter logic [RATIO_W-1:0]           DEF_IDIV     = RATIO_W'(1),
  parameter logic [RATIO_W-1:0]           DEF_FDIV     = RATIO_W'(24),
  parameter logic [NUM_OUT*RATIO_W-1:0]   DEF_ODIV     = {NUM_OUT{10'd5}},
  parameter logic [NUM_OUT*RATIO_W-1:0]   DEF_DUTY     = {NUM_OUT{10'd5}},
  parameter int                           RST_CYCLES   = 16,
  parameter int                           LOCK_FILTER  = 64,
  parameter int                           LOCK_TIMEOUT = 4096,
  parameter int                           MAX_RETRY    = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [RATIO_W-1:0]           cfg_idiv,
  input  logic [RATIO_W-1:0]           cfg_fdiv,
  input  logic [NUM_OUT*RATIO_W-1:0]   cfg_odiv,
  input  logic [NUM_OUT*RATIO_W-1:0]   cfg_duty,
  input  logic                         pll_lock_raw,
  output logic                         pll_rst,
  output logic [RATIO_W-1:0]           ratioi,
  output logic [RATIO_W-1:0]           ratiof,
  output logic [NUM_OUT*RATIO_W-1:0]   ratio_o,
  output logic [NUM_OUT*RATIO_W-1:0]   duty_o,
  output logic                         clk_ready,
  output logic                         busy,
  output logic                         cfg_err,
  output logic                         fail,
  output logic [7:0]                   lock_loss_cnt
);

  localparam int RST_W  = $clog2(RST_CYCLES + 1);
  localparam int FILT_W = $clog2(LOCK_FILTER + 1);
  localparam int TO_W   = $clog2(LOCK_TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(LOCK_FILTER - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FAIL   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [RST_W-1:0]    rst_cnt, rst_cnt_nxt;
  logic [FILT_W-1:0]   filt_cnt, filt_nxt;
  logic [TO_W-1:0]     to_cnt, to_nxt;
  logic [RTY_W-1:0]    rty_cnt, rty_nxt;
  logic [7:0]          llc_nxt;
  logic                err_nxt;
  logic                load_cfg;
  logic                xfer;
  logic                cfg_ok;
  logic                lock_meta, lock_s;

  // Two-flop synchroniser for the asynchronous PLL lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock_raw;
      lock_s    <= lock_meta;
    end
  end

  // Duty is in half-VCO-cycle units, so it must stay below 2*odiv. The
  // comparison uses one extra bit so that 2*odiv cannot overflow.
  function automatic logic cfg_is_valid(
    input logic [RATIO_W-1:0]         idiv,
    input logic [RATIO_W-1:0]         fdiv,
    input logic [NUM_OUT*RATIO_W-1:0] odiv,
    input logic [NUM_OUT*RATIO_W-1:0] duty
  );
    logic               ok;
    logic [RATIO_W-1:0] od;
    logic [RATIO_W-1:0] du;
    ok = (idiv != '0) && (fdiv != '0);
    for (int ch = 0; ch < NUM_OUT; ch++) begin
      od = odiv[ch*RATIO_W +: RATIO_W];
      du = duty[ch*RATIO_W +: RATIO_W];
      if (od == '0 || du == '0) ok = 1'b0;
      if ({1'b0, du} >= {od, 1'b0}) ok = 1'b0;
    end
    return ok;
  endfunction

  assign cfg_ok    = cfg_is_valid(cfg_idiv, cfg_fdiv, cfg_odiv, cfg_duty);
  assign cfg_ready = (state == ST_LOCKED) || (state == ST_FAIL);
  assign xfer      = cfg_valid && cfg_ready;
  assign busy      = (state == ST_RESET) || (state == ST_WAIT);
  assign fail      = (state == ST_FAIL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_RESET;
      rst_cnt       <= '0;
      filt_cnt      <= '0;
      to_cnt        <= '0;
      rty_cnt       <= '0;
      lock_loss_cnt <= '0;
      cfg_err       <= 1'b0;
    end else begin
      state         <= state_nxt;
      rst_cnt       <= rst_cnt_nxt;
      filt_cnt      <= filt_nxt;
      to_cnt        <= to_nxt;
      rty_cnt       <= rty_nxt;
      lock_loss_cnt <= llc_nxt;
      cfg_err       <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    filt_nxt    = filt_cnt;
    to_nxt      = to_cnt;
    rty_nxt     = rty_cnt;
    llc_nxt     = lock_loss_cnt;
    err_nxt     = 1'b0;
    load_cfg    = 1'b0;

    case (state)
      ST_RESET: begin
        if (rst_cnt == RST_LAST) begin
          state_nxt   = ST_WAIT;
          rst_cnt_nxt = '0;
          filt_nxt    = '0;
          to_nxt      = '0;
        end else begin
          rst_cnt_nxt = rst_cnt + 1'b1;
        end
      end
      ST_WAIT: begin
        filt_nxt = lock_s ? filt_cnt + 1'b1 : '0;
        to_nxt   = to_cnt + 1'b1;
        // Filter completion is checked first so it wins over a coincident timeout.
        if (lock_s && filt_cnt == FILT_LAST) begin
          state_nxt = ST_LOCKED;
          rty_nxt   = '0;
          filt_nxt  = '0;
          to_nxt    = '0;
        end else if (to_cnt == TO_LAST) begin
          filt_nxt = '0;
          to_nxt   = '0;
          if (rty_cnt < RTY_MAX) begin
            rty_nxt     = rty_cnt + 1'b1;
            rst_cnt_nxt = '0;
            state_nxt   = ST_RESET;
          end else begin
            state_nxt = ST_FAIL;
          end
        end
      end
      ST_LOCKED: begin
        // Lock loss re-qualifies without touching the PLL reset.
        if (!lock_s) begin
          if (lock_loss_cnt != 8'hFF) llc_nxt = lock_loss_cnt + 8'd1;
          state_nxt = ST_WAIT;
          filt_nxt  = '0;
          to_nxt    = '0;
        end
      end
      ST_FAIL: begin
      end
      default: state_nxt = ST_RESET;
    endcase

    // A request overrides the state decision above. An accepted request keeps
    // any lock-loss count from the same cycle; a rejected one freezes everything.
    if (xfer) begin
      if (cfg_ok) begin
        load_cfg    = 1'b1;
        state_nxt   = ST_RESET;
        rst_cnt_nxt = '0;
        rty_nxt     = '0;
        filt_nxt    = '0;
        to_nxt      = '0;
      end else begin
        err_nxt   = 1'b1;
        state_nxt = state;
        filt_nxt  = filt_cnt;
        to_nxt    = to_cnt;
        llc_nxt   = lock_loss_cnt;
      end
    end
  end

  // pll_rst and clk_ready are registered so that the PLL pin and the system
  // see clean levels rather than a decode of the state bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
    end else begin
      pll_rst   <= (state_nxt == ST_RESET) || (state_nxt == ST_FAIL);
      clk_ready <= (state_nxt == ST_LOCKED);
    end
  end

  // Ratios load only together with the move to RESET, so they never change
  // while the PLL is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ratioi  <= DEF_IDIV;
      ratiof  <= DEF_FDIV;
      ratio_o <= DEF_ODIV;
      duty_o  <= DEF_DUTY;
    end else if (load_cfg) begin
      ratioi  <= cfg_idiv;
      ratiof  <= cfg_fdiv;
      ratio_o <= cfg_odiv;
      duty_o  <= cfg_duty;
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
module tb_pll_dyn_ctrl;

  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [RW-1:0] cfg_idiv = 10'd1;
  logic [RW-1:0] cfg_fdiv = 10'd24;
  logic [RW-1:0] cfg_odiv = 10'd5;
  logic [RW-1:0] cfg_duty = 10'd5;
  logic          pll_lock_raw = 1'b0;
  logic          pll_rst;
  logic [RW-1:0] ratioi, ratiof, ratio_o, duty_o;
  logic          clk_ready, busy, cfg_err, fail;
  logic [7:0]    lock_loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pll_dyn_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idiv      (cfg_idiv),
    .cfg_fdiv      (cfg_fdiv),
    .cfg_odiv      (cfg_odiv),
    .cfg_duty      (cfg_duty),
    .pll_lock_raw  (pll_lock_raw),
    .pll_rst       (pll_rst),
    .ratioi        (ratioi),
    .ratiof        (ratiof),
    .ratio_o       (ratio_o),
    .duty_o        (duty_o),
    .clk_ready     (clk_ready),
    .busy          (busy),
    .cfg_err       (cfg_err),
    .fail          (fail),
    .lock_loss_cnt (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts negedges for which pll_rst holds the given level.
  task automatic meas_level(input logic lvl, input int limit, output int n);
    n = 0;
    while (pll_rst === lvl && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_ready(input int limit, output int n);
    n = 0;
    while (clk_ready !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic send(input logic [RW-1:0] i, input logic [RW-1:0] f,
                      input logic [RW-1:0] o, input logic [RW-1:0] d);
    cfg_idiv  = i;
    cfg_fdiv  = f;
    cfg_odiv  = o;
    cfg_duty  = d;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  // Rejected requests: {idiv, fdiv, odiv, duty}
  logic [RW-1:0] rej_tab [6][4] = '{
    '{10'd1, 10'd24, 10'd5, 10'd10},
    '{10'd2, 10'd40, 10'd8, 10'd16},
    '{10'd0, 10'd40, 10'd8, 10'd8},
    '{10'd2, 10'd0,  10'd8, 10'd8},
    '{10'd2, 10'd40, 10'd0, 10'd1},
    '{10'd2, 10'd40, 10'd8, 10'd0}
  };

  initial begin
    int n;
    int hi, lo;
    logic rst_seen;

    // Power-on reset values
    cyc(3);
    check("rst_pll_rst", pll_rst, 1);
    check("rst_busy", busy, 1);
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_clk_ready", clk_ready, 0);
    check("rst_fail", fail, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_ratioi", ratioi, 1);
    check("rst_ratiof", ratiof, 24);
    check("rst_ratio_o", ratio_o, 5);
    check("rst_duty_o", duty_o, 5);
    check("rst_llc", lock_loss_cnt, 0);

    // Power-on sequence, lock 100 cycles after pll_rst falls
    rst_n = 1'b1;
    meas_level(1'b1, 100, n);
    check("po_rst_len", n, 16);
    cyc(100);
    pll_lock_raw = 1'b1;
    wait_ready(300, n);
    check("po_lock_lat", (n >= 65 && n <= 67) ? 1 : 0, 1);
    check("po_ratioi", ratioi, 1);
    check("po_ratiof", ratiof, 24);
    check("po_ratio_o", ratio_o, 5);
    check("po_duty_o", duty_o, 5);
    check("po_busy", busy, 0);
    check("po_cfg_ready", cfg_ready, 1);
    check("po_pll_rst", pll_rst, 0);

    // Accepted reconfiguration from LOCKED
    send(10'd2, 10'd40, 10'd8, 10'd8);
    check("rq_ratioi", ratioi, 2);
    check("rq_ratiof", ratiof, 40);
    check("rq_ratio_o", ratio_o, 8);
    check("rq_duty_o", duty_o, 8);
    check("rq_pll_rst", pll_rst, 1);
    check("rq_clk_ready", clk_ready, 0);
    check("rq_cfg_err", cfg_err, 0);
    check("rq_busy", busy, 1);
    meas_level(1'b1, 100, n);
    check("rq_rst_len", n, 16);
    check("rq_clk_ready_low", clk_ready, 0);
    wait_ready(300, n);
    check("rq_relock_lat", n, 64);
    check("rq_llc", lock_loss_cnt, 0);

    // Rejected requests leave everything untouched
    for (int k = 0; k < 6; k++) begin
      send(rej_tab[k][0], rej_tab[k][1], rej_tab[k][2], rej_tab[k][3]);
      check($sformatf("rej%0d_cfg_err", k), cfg_err, 1);
      check($sformatf("rej%0d_ratioi", k), ratioi, 2);
      check($sformatf("rej%0d_ratio_o", k), ratio_o, 8);
      check($sformatf("rej%0d_duty_o", k), duty_o, 8);
      check($sformatf("rej%0d_clk_ready", k), clk_ready, 1);
      check($sformatf("rej%0d_pll_rst", k), pll_rst, 0);
      cyc(1);
      check($sformatf("rej%0d_err_pulse", k), cfg_err, 0);
    end

    // 5-cycle lock glitch while LOCKED
    rst_seen = 1'b0;
    pll_lock_raw = 1'b0;
    n = 0;
    while (clk_ready === 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
      if (pll_rst) rst_seen = 1'b1;
    end
    check("gl_drop_lat", (n >= 1 && n <= 3) ? 1 : 0, 1);
    cyc(5 - n);
    pll_lock_raw = 1'b1;
    n = 0;
    while (clk_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
      if (pll_rst) rst_seen = 1'b1;
    end
    check("gl_relock_lat", (n >= 65 && n <= 67) ? 1 : 0, 1);
    check("gl_no_pll_rst", rst_seen, 0);
    check("gl_llc", lock_loss_cnt, 1);

    // Request coinciding with a lock drop: request wins, count still bumps
    pll_lock_raw = 1'b0;
    cyc(2);
    send(10'd3, 10'd30, 10'd6, 10'd11);
    check("sim_pll_rst", pll_rst, 1);
    check("sim_llc", lock_loss_cnt, 2);
    check("sim_ratioi", ratioi, 3);
    check("sim_duty_o", duty_o, 11);
    check("sim_clk_ready", clk_ready, 0);
    check("sim_cfg_err", cfg_err, 0);

    // rst_n pulse during WAIT_LOCK
    meas_level(1'b1, 100, n);
    check("wl_rst_len", n, 16);
    cyc(10);
    check("wl_busy", busy, 1);
    check("wl_pll_rst", pll_rst, 0);
    rst_n = 1'b0;
    #1;
    check("ar_pll_rst", pll_rst, 1);
    check("ar_ratioi", ratioi, 1);
    check("ar_ratiof", ratiof, 24);
    check("ar_ratio_o", ratio_o, 5);
    check("ar_duty_o", duty_o, 5);
    check("ar_llc", lock_loss_cnt, 0);
    check("ar_busy", busy, 1);
    check("ar_cfg_ready", cfg_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Lock never arrives: 4 reset pulses each followed by a full timeout
    for (int r = 0; r < 4; r++) begin
      meas_level(1'b1, 100, hi);
      check($sformatf("rt%0d_rst_len", r), hi, 16);
      meas_level(1'b0, 5000, lo);
      check($sformatf("rt%0d_wait_len", r), lo, 4096);
    end
    check("fl_fail", fail, 1);
    check("fl_cfg_ready", cfg_ready, 1);
    check("fl_busy", busy, 0);
    cyc(20);
    check("fl_pll_rst_held", pll_rst, 1);
    check("fl_fail_held", fail, 1);

    // Bad request in FAIL is rejected, good one restarts the sequence
    send(10'd0, 10'd24, 10'd5, 10'd5);
    check("fr_cfg_err", cfg_err, 1);
    check("fr_fail", fail, 1);
    pll_lock_raw = 1'b1;
    send(10'd1, 10'd24, 10'd5, 10'd9);
    check("fa_fail", fail, 0);
    check("fa_pll_rst", pll_rst, 1);
    check("fa_busy", busy, 1);
    check("fa_duty_o", duty_o, 9);
    wait_ready(400, n);
    check("fa_lock_lat", n, 80);
    check("fa_clk_ready", clk_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
